// File: rtl/mem_responder.sv
// mem_responder: target-side responder for the en/wr/addr access bus.
// Accepts one request at a time, inserts WAIT_CYC wait states, then
// performs the access on an internal DEPTH x DW array and pulses done.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready=1, waiting for en
// S_ACC  | one cycle, request has been latched
// S_WAIT | WAIT_CYC cycles, timed by the wait down-counter
// S_RESP | one cycle, done (and rvalid/err) high, access performed
module mem_responder #(
   parameter int DW       = 8,
   parameter int AW       = 6,
   parameter int DEPTH    = 64,
   parameter int WAIT_CYC = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          wr,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          ready,
   output logic          done,
   output logic          rvalid,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic [7:0]    wr_cnt,
   output logic [7:0]    rd_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_RESP} state_t;

   // The counter is loaded with WAIT_CYC-1 so terminal count (0) marks the
   // last wait cycle; with WAIT_CYC=0 the WAIT state is skipped entirely.
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
   localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

   state_t          state_q, state_d;
   logic [3:0]      wait_cnt;
   logic            wr_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW-1:0]   mem [DEPTH];
   logic            accept;
   logic            enter_resp;
   logic            in_range;

   assign accept     = (state_q == S_IDLE) && en;
   assign enter_resp = (state_d == S_RESP);
   assign in_range   = ({1'b0, addr_q} < DEPTH_LIM);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode; RESP is entered only from ACC or WAIT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (en) state_d = S_ACC;
         S_ACC:  state_d = (WAIT_CYC > 0) ? S_WAIT : S_RESP;
         S_WAIT: if (wait_cnt == 4'd0) state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Wait-state down-counter, reloaded every ACC cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         wait_cnt <= 4'd0;
      else if (state_q == S_ACC)                       wait_cnt <= WAIT_LOAD;
      else if (state_q == S_WAIT && wait_cnt != 4'd0)  wait_cnt <= wait_cnt - 4'd1;
   end

   // Request latch; inputs are only looked at on the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         wr_q    <= wr;
         addr_q  <= addr;
         wdata_q <= wdata;
      end
   end

   // Storage array; written only on the edge entering RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (enter_resp && wr_q && in_range) begin
         mem[addr_q] <= wdata_q;
      end
   end

   // Registered outputs: ready mirrors the next state, pulses and counters
   // update on RESP entry so an aborted transaction leaves no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready  <= 1'b1;
         done   <= 1'b0;
         rvalid <= 1'b0;
         err    <= 1'b0;
         rdata  <= '0;
         wr_cnt <= 8'd0;
         rd_cnt <= 8'd0;
      end else begin
         ready  <= (state_d == S_IDLE);
         done   <= enter_resp;
         rvalid <= enter_resp && !wr_q && in_range;
         err    <= enter_resp && !in_range;
         if (enter_resp) begin
            if (!in_range) begin
               rdata <= '0;
            end else if (wr_q) begin
               wr_cnt <= wr_cnt + 8'd1;
            end else begin
               rdata  <= mem[addr_q];
               rd_cnt <= rd_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized traffic
// checked against a simple array/counter model of the responder.
`timescale 1ns/1ps
module tb_mem_responder;

   localparam int DW       = 8;
   localparam int AW       = 6;
   localparam int DEPTH    = 48;
   localparam int WAIT_CYC = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          wr = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic          ready, done, rvalid, err;
   logic [DW-1:0] rdata;
   logic [7:0]    wr_cnt, rd_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: storage, counters and last read data.
   logic [7:0] model_mem [64];
   int         model_wr;
   int         model_rd;
   logic [7:0] model_rdata;

   mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_CYC(WAIT_CYC)) dut (
      .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
      .ready(ready), .done(done), .rvalid(rvalid), .rdata(rdata), .err(err),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
   );

   always #20 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear;
      for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
      model_wr = 0;
      model_rd = 0;
      model_rdata = 8'h00;
   endtask

   // Applies one completed transaction to the model and returns the
   // pulses expected alongside done.
   task automatic model_txn(input logic w, input int a, input logic [7:0] d,
                            output logic exp_err, output logic exp_rvalid);
      exp_err = (a >= DEPTH);
      exp_rvalid = !w && (a < DEPTH);
      if (a >= DEPTH) begin
         model_rdata = 8'h00;
      end else if (w) begin
         model_mem[a] = d;
         model_wr = (model_wr + 1) % 256;
      end else begin
         model_rdata = model_mem[a];
         model_rd = (model_rd + 1) % 256;
      end
   endtask

   // Drives one request from IDLE and leaves time just after RESP entry.
   task automatic start_txn(input logic w, input logic [AW-1:0] a, input logic [7:0] d);
      en = 1'b1; wr = w; addr = a; wdata = d;
      step;
      en = 1'b0;
      repeat (WAIT_CYC + 1) step;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
      step;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
      checks++; if ({done, rvalid, err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {done, rvalid, err}); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
      checks++; if ({wr_cnt, rd_cnt} !== 16'h0000) begin errors++; $display("FAIL reset_cnts: got %h/%h expected 00/00", wr_cnt, rd_cnt); end
   endtask

   task automatic test_write_read;
      logic e_err, e_rv;
      en = 1'b1; wr = 1'b1; addr = 6'd12; wdata = 8'hA5;
      step; // E0
      en = 1'b0;
      checks++; if (ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL wr_e0: got ready=%b done=%b expected 0/0", ready, done); end
      step; // E1
      checks++; if (ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL wr_e1: got ready=%b done=%b expected 0/0", ready, done); end
      step; // E2
      model_txn(1'b1, 12, 8'hA5, e_err, e_rv);
      checks++; if ({done, rvalid, err} !== 3'b100) begin errors++; $display("FAIL wr_resp: got %b expected 100", {done, rvalid, err}); end
      checks++; if (wr_cnt !== 8'(model_wr) || ready !== 1'b0) begin errors++; $display("FAIL wr_cnt: got %0d ready=%b expected %0d ready=0", wr_cnt, ready, model_wr); end
      step; // E3
      checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL wr_e3: got ready=%b done=%b expected 1/0", ready, done); end
      start_txn(1'b0, 6'd12, 8'h00);
      model_txn(1'b0, 12, 8'h00, e_err, e_rv);
      checks++; if ({done, rvalid, err} !== 3'b110) begin errors++; $display("FAIL rd_resp: got %b expected 110", {done, rvalid, err}); end
      checks++; if (rdata !== 8'hA5 || rd_cnt !== 8'(model_rd)) begin errors++; $display("FAIL rd_data: got %h cnt=%0d expected a5 cnt=%0d", rdata, rd_cnt, model_rd); end
      step;
   endtask

   task automatic test_held_en;
      logic e_err, e_rv;
      int dones;
      dones = 0;
      en = 1'b1; wr = 1'b1; addr = 6'd14; wdata = 8'h11;
      step; // E0
      addr = 6'd23; wdata = 8'h22;
      for (int k = 1; k <= 3; k++) begin
         step; // E1..E3
         if (done) dones++;
      end
      model_txn(1'b1, 14, 8'h11, e_err, e_rv);
      checks++; if (dones !== 1 || wr_cnt !== 8'(model_wr)) begin errors++; $display("FAIL held_first: got dones=%0d wr_cnt=%0d expected 1/%0d", dones, wr_cnt, model_wr); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL held_ready_e3: got %b expected 1", ready); end
      step; // E4 accepts addr 23
      en = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL held_accept_e4: got ready=%b expected 0", ready); end
      repeat (WAIT_CYC + 1) step;
      model_txn(1'b1, 23, 8'h22, e_err, e_rv);
      checks++; if (done !== 1'b1 || wr_cnt !== 8'(model_wr)) begin errors++; $display("FAIL held_second: got done=%b wr_cnt=%0d expected 1/%0d", done, wr_cnt, model_wr); end
      step;
      start_txn(1'b0, 6'd14, 8'h00);
      model_txn(1'b0, 14, 8'h00, e_err, e_rv);
      checks++; if (rdata !== model_rdata) begin errors++; $display("FAIL held_rd14: got %h expected %h", rdata, model_rdata); end
      step;
      start_txn(1'b0, 6'd23, 8'h00);
      model_txn(1'b0, 23, 8'h00, e_err, e_rv);
      checks++; if (rdata !== model_rdata) begin errors++; $display("FAIL held_rd23: got %h expected %h", rdata, model_rdata); end
      step;
   endtask

   task automatic test_out_of_range;
      logic e_err, e_rv;
      start_txn(1'b0, 6'd56, 8'h00);
      model_txn(1'b0, 56, 8'h00, e_err, e_rv);
      checks++; if ({done, rvalid, err} !== 3'b101) begin errors++; $display("FAIL oor_pulses: got %b expected 101", {done, rvalid, err}); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL oor_rdata: got %h expected 00", rdata); end
      checks++; if (wr_cnt !== 8'(model_wr) || rd_cnt !== 8'(model_rd)) begin errors++; $display("FAIL oor_cnts: got %0d/%0d expected %0d/%0d", wr_cnt, rd_cnt, model_wr, model_rd); end
      step;
      start_txn(1'b1, 6'd50, 8'h77);
      model_txn(1'b1, 50, 8'h77, e_err, e_rv);
      checks++; if (err !== 1'b1 || wr_cnt !== 8'(model_wr)) begin errors++; $display("FAIL oor_write: got err=%b wr_cnt=%0d expected 1/%0d", err, wr_cnt, model_wr); end
      step;
   endtask

   task automatic test_reset_mid;
      logic e_err, e_rv;
      en = 1'b1; wr = 1'b1; addr = 6'd40; wdata = 8'h3C;
      step; // E0
      en = 1'b0;
      step; // E1, in WAIT
      rst = 1'b1;
      #1;
      checks++; if ({ready, done, rvalid, err} !== 4'b1000) begin errors++; $display("FAIL rstmid_flags: got %b expected 1000", {ready, done, rvalid, err}); end
      checks++; if (rdata !== 8'h00 || wr_cnt !== 8'h00 || rd_cnt !== 8'h00) begin errors++; $display("FAIL rstmid_regs: got %h/%0d/%0d expected 00/0/0", rdata, wr_cnt, rd_cnt); end
      model_clear();
      step;
      @(negedge clk) rst = 1'b0;
      step;
      checks++; if (done !== 1'b0 || wr_cnt !== 8'h00) begin errors++; $display("FAIL rstmid_nodone: got done=%b wr_cnt=%0d expected 0/0", done, wr_cnt); end
      start_txn(1'b0, 6'd40, 8'h00);
      model_txn(1'b0, 40, 8'h00, e_err, e_rv);
      checks++; if (rvalid !== 1'b1 || rdata !== 8'h00) begin errors++; $display("FAIL rstmid_rd40: got rvalid=%b rdata=%h expected 1/00", rvalid, rdata); end
      step;
   endtask

   task automatic test_back_to_back;
      logic e_err, e_rv;
      logic [7:0] d;
      int a;
      int bad;
      bad = 0;
      for (int n = 0; n < 256; n++) begin
         a = $urandom_range(0, DEPTH - 1);
         d = 8'($urandom);
         start_txn(1'b1, 6'(a), d);
         model_txn(1'b1, a, d, e_err, e_rv);
         if (done !== 1'b1) bad++;
         step;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_done: got %0d missing pulses expected 0", bad); end
      checks++; if (wr_cnt !== 8'h00 || wr_cnt !== 8'(model_wr)) begin errors++; $display("FAIL b2b_wrap256: got %0d expected 0", wr_cnt); end
      start_txn(1'b1, 6'd1, 8'h5A);
      model_txn(1'b1, 1, 8'h5A, e_err, e_rv);
      checks++; if (wr_cnt !== 8'h01) begin errors++; $display("FAIL b2b_257: got %0d expected 1", wr_cnt); end
      step;
   endtask

   task automatic test_random;
      logic e_err, e_rv;
      logic w;
      logic [7:0] d;
      int a;
      for (int n = 0; n < 120; n++) begin
         w = 1'($urandom);
         a = $urandom_range(0, 63);
         d = 8'($urandom);
         start_txn(w, 6'(a), d);
         model_txn(w, a, d, e_err, e_rv);
         checks++;
         if (done !== 1'b1 || err !== e_err || rvalid !== e_rv || rdata !== model_rdata ||
             wr_cnt !== 8'(model_wr) || rd_cnt !== 8'(model_rd)) begin
            errors++;
            $display("FAIL rand_txn%0d: got done=%b err=%b rv=%b rd=%h wc=%0d rc=%0d expected 1 %b %b %h %0d %0d",
                     n, done, err, rvalid, rdata, wr_cnt, rd_cnt, e_err, e_rv, model_rdata, model_wr, model_rd);
         end
         step;
         checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rand_idle%0d: got ready=%b done=%b expected 1/0", n, ready, done); end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_held_en();
      test_out_of_range();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
